seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU_sel produced by the ALU control unit, together with the two 32-bit operands.
- Logic and arithmetic ops complete in one cycle.
- Shifts run iteratively, one bit position per cycle, and hold the unit busy while they run.
- Valid/ready handshakes on both sides let the core stall on long shifts. Result and flags go to writeback and branch logic.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width (log2 WIDTH); taken from op_b[SHAMT_W-1:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  operands and alu_sel valid this cycle
- in_ready  out  1  unit can accept an operation this cycle
- alu_sel  in  4  operation select (encoding below)
- op_a  in  WIDTH  operand A / shift source
- op_b  in  WIDTH  operand B / shift amount
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- zf  out  1  result == 0
- cf  out  1  carry out (ADD/SUB only)
- vf  out  1  signed overflow (ADD/SUB only)
- sf  out  1  result[WIDTH-1]
- busy  out  1  high in SHIFT state

Behaviour:
- alu_sel encoding (matches ALU control unit):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR
  - 0111 SLT (signed), 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA
  - any other code: result 0, all flags 0, latency 1.
- Reset (rst==0 at clk edge):
  - state=IDLE; out_valid=0; result=0; zf=cf=vf=sf=0; busy=0; shift counter=0.
  - Applies mid-shift or mid-hold; the pending op is dropped and not reported.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid, the op is accepted.
    - Non-shift op, or shift with shamt==0: compute, register result/flags, go to DONE.
    - Shift with shamt>0: load shift reg=op_a and counter=shamt, go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle the shift reg moves one position (SLL: zero fill; SRL: zero fill; SRA: sign fill) and the counter decrements. When the counter reaches 1, the final value is registered and the FSM goes to DONE.
  - DONE: out_valid=1; result/flags held stable until out_ready.
    - out_ready=1 and in_valid=1: in_ready=1, so the result retires and the new op is accepted in the same cycle (back-to-back, no bubble).
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: in_ready=0 and the FSM stays in DONE.
- Latency from accept to out_valid:
  - 1 cycle for non-shift ops and shamt==0.
  - shamt+1 cycles for shifts.
  - Throughput: 1 op/cycle for non-shift ops under continuous out_ready.
- Arithmetic:
  - ADD: {cf,result}=a+b. SUB: {cf,result}=a+~b+1, so cf=1 means no borrow.
  - vf = (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]), where b' = b for ADD and ~b for SUB.
  - SLT/SLTU: result is 1 or 0, zero-extended.
  - Shift amount is op_b[4:0] only; upper bits are ignored.
- Flags: zf and sf are computed for every op. cf and vf are 0 for all non-ADD/SUB ops.
- in_valid while in_ready==0 is ignored; the upstream holds its inputs.
- Inputs are sampled only on the accept cycle; later changes to op_a/op_b/alu_sel do not affect an op in flight.

Decomposition:
- Shared package alu_pkg:
  - localparams for all 4-bit ALU_sel codes and the 2-bit ALUOp values, shared with the ALU control unit.
  - FSM state encoding constants.
- One sub-module, alu_comb_core: a combinational single-cycle datapath (AND/OR/XOR/ADD/SUB/SLT/SLTU plus flags), instantiated once.
- The shift engine and FSM live in seq_alu.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, then release -> out_valid=0, result=0, all flags 0, in_ready=1. Also assert rst=0 mid-SHIFT -> next cycle state IDLE, out_valid=0.
- ADD overflow: ADD a=0x7FFFFFFF, b=1 -> 1 cycle later result=0x80000000, vf=1, sf=1, cf=0, zf=0.
- SUB equal operands: SUB a=5, b=5 -> result=0, zf=1, cf=1, vf=0.
- SLT signed vs unsigned: SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0.
- Shift latency and fill: SRA a=0x80000000, b=0x24 (shamt=4) -> busy for 4 cycles, out_valid on cycle 5, result=0xF8000000. SLL with shamt=0 -> result=a after 1 cycle.
- Backpressure and back-to-back: hold out_ready=0 for 3 cycles after an ADD -> result stable, in_ready=0. Then raise out_ready together with in_valid (AND 0xF0F0, 0x0FF0) -> the ADD retires and the AND result 0x00F0 appears the next cycle with no gap.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select codes, ALUOp values from the decoder,
// FSM state encoding and the flag bundle used by the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSll  = 4'b1001;
  localparam logic [3:0] AluSrl  = 4'b1010;
  localparam logic [3:0] AluSra  = 4'b1011;

  // ALUOp values driven by the main decoder into the ALU control unit
  localparam logic [1:0] AluOpMem    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;
  localparam logic [1:0] AluOpImm    = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  typedef struct packed {
    logic zf;
    logic cf;
    logic vf;
    logic sf;
  } flags_t;

  function automatic logic is_shift_sel(input logic [3:0] sel);
    return (sel == AluSll) || (sel == AluSrl) || (sel == AluSra);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Handshake bundle between the issue logic (master) and the sequential ALU (slave).
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             cf;
  logic             vf;
  logic             sf;
  logic             busy;

  modport master (
    output in_valid, alu_sel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zf, cf, vf, sf, busy
  );

  modport slave (
    input  in_valid, alu_sel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zf, cf, vf, sf, busy
  );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle datapath for logic, add/sub and compare ops with flags.
// Shift and unknown codes yield zero result and zero flags here.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic             is_sub;
  logic             known;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    is_sub = (alu_sel == AluSub);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    result = '0;
    flags  = '0;
    known  = 1'b1;
    case (alu_sel)
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluAdd, AluSub: begin
        result   = sum[WIDTH-1:0];
        flags.cf = sum[WIDTH];
        flags.vf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      AluSlt:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu: result = {{(WIDTH-1){1'b0}}, a < b};
      default: known = 1'b0;
    endcase
    // unknown codes report all flags clear, including zf
    flags.zf = known && (result == '0);
    flags.sf = result[WIDTH-1];
  end

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/arith via alu_comb_core, iterative one-bit-per-cycle
// shifter, valid/ready on both sides with back-to-back retire/accept in DONE.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);

  localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         shsel_q, shsel_d;
  logic [WIDTH-1:0]   result_q, result_d;
  flags_t             flags_q, flags_d;

  logic [WIDTH-1:0]   core_result;
  flags_t             core_flags;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] shamt;
  logic               in_ready, out_valid, busy;

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .alu_sel (bus.alu_sel),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .result  (core_result),
    .flags   (core_flags)
  );

  assign shamt = bus.op_b[SHAMT_W-1:0];

  always_comb begin
    case (shsel_q)
      AluSll:  shifted = {shreg_q[WIDTH-2:0], 1'b0};
      AluSrl:  shifted = {1'b0, shreg_q[WIDTH-1:1]};
      default: shifted = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    shsel_d   = shsel_q;
    result_d  = result_q;
    flags_d   = flags_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      StIdle: in_ready = 1'b1;
      StShift: begin
        busy = 1'b1;
        if (cnt_q == CntOne) begin
          state_d  = StDone;
          cnt_d    = '0;
          result_d = shifted;
          flags_d  = '{zf: (shifted == '0), cf: 1'b0, vf: 1'b0, sf: shifted[WIDTH-1]};
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q - CntOne;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready && !bus.in_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // accept overrides the DONE->IDLE transition so retire and issue share a cycle
    if (in_ready && bus.in_valid) begin
      if (is_shift_sel(bus.alu_sel) && (shamt != '0)) begin
        state_d = StShift;
        shreg_d = bus.op_a;
        cnt_d   = shamt;
        shsel_d = bus.alu_sel;
      end else if (is_shift_sel(bus.alu_sel)) begin
        state_d  = StDone;
        result_d = bus.op_a;
        flags_d  = '{zf: (bus.op_a == '0), cf: 1'b0, vf: 1'b0, sf: bus.op_a[WIDTH-1]};
      end else begin
        state_d  = StDone;
        result_d = core_result;
        flags_d  = core_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      shsel_q  <= AluSll;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      shsel_q  <= shsel_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.result    = result_q;
  assign bus.zf        = flags_q.zf;
  assign bus.cf        = flags_q.cf;
  assign bus.vf        = flags_q.vf;
  assign bus.sf        = flags_q.sf;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner ops plus randomized ops with random
// backpressure, checked against an arithmetic reference model.
module tb_seq_alu;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        cf;
    logic        vf;
    logic        sf;
    int          lat;
    int          acc;
  } exp_t;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rnd_bp = 1'b0;
  exp_t exp_q[$];

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic [3:0] zcvs, input int lat);
    exp_t e;
    e.res = res;
    {e.zf, e.cf, e.vf, e.sf} = zcvs;
    e.lat = lat;
    e.acc = 0;
    return e;
  endfunction

  // Reference model: plain arithmetic on the operation's meaning
  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    int     sh;
    bit     known;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    e = mk(32'h0, 4'b0000, 1);
    known = 1'b1;
    case (sel)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h3: e.res = a ^ b;
      4'h2: begin
        {e.cf, e.res} = {1'b0, a} + {1'b0, b};
        s = sa + sb;
        e.vf = (s > SMax) || (s < SMin);
      end
      4'h6: begin
        e.res = a - b;
        e.cf = (a >= b);
        s = sa - sb;
        e.vf = (s > SMax) || (s < SMin);
      end
      4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: e.res = (a < b) ? 32'd1 : 32'd0;
      4'h9: begin e.res = a << sh; e.lat = sh + 1; end
      4'hA: begin e.res = a >> sh; e.lat = sh + 1; end
      4'hB: begin e.res = $signed(a) >>> sh; e.lat = sh + 1; end
      default: known = 1'b0;
    endcase
    e.zf = known && (e.res == 32'h0);
    e.sf = e.res[31];
    return e;
  endfunction

  // Drive one op until accepted, then record its expectation with the accept cycle
  task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.alu_sel  = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 64'(n), 64'd0);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (rnd_bp) bus.out_ready = ($urandom_range(3) != 0);
    end
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_sel  = 4'($urandom);
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_bp) bus.out_ready = ($urandom_range(3) != 0);
    end
  endtask

  // Monitor: checks every presented output against the scoreboard head
  initial begin
    bit   hold = 1'b0;
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          h = exp_q[0];
          if (!hold) check("latency", 64'(cyc - h.acc), 64'(h.lat));
          check("result", 64'(bus.result), 64'(h.res));
          check("flags_zcvs", 64'({bus.zf, bus.cf, bus.vf, bus.sf}),
                64'({h.zf, h.cf, h.vf, h.sf}));
          check("busy_in_done", 64'(bus.busy), 64'd0);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            hold = 1'b0;
          end else begin
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            hold = 1'b1;
          end
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    logic [3:0]  sel;
    logic [31:0] a, b;
    int          nbusy;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_sel   = 4'h0;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_flags", 64'({bus.zf, bus.cf, bus.vf, bus.sf}), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;

    issue(4'h2, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 4'b0011, 1));
    issue(4'h6, 32'h5, 32'h5, mk(32'h0, 4'b1100, 1));
    issue(4'h7, 32'hFFFF_FFFF, 32'h1, mk(32'h1, 4'b0000, 1));
    issue(4'h8, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 4'b1000, 1));
    issue(4'h9, 32'h1234_5678, 32'h20, mk(32'h1234_5678, 4'b0000, 1));
    issue(4'hD, 32'hFFFF_FFFF, 32'h3, mk(32'h0, 4'b0000, 1));

    issue(4'hB, 32'h8000_0000, 32'h24, mk(32'hF800_0000, 4'b0001, 5));
    nbusy = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
    end
    check("sra_busy_cycles", 64'(nbusy), 64'd4);
    @(posedge clk);
    #1;

    // backpressure, then retire and accept in the same cycle
    bus.out_ready = 1'b0;
    issue(4'h2, 32'h10, 32'h20, mk(32'h30, 4'b0000, 1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(4'h0, 32'hF0F0, 32'h0FF0, mk(32'h00F0, 4'b0000, 1));
    idle(2);

    // reset in the middle of a long shift drops the op
    issue(4'h9, 32'h1, 32'd20, mk(32'h0010_0000, 4'b0000, 21));
    idle(3);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midshift_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midshift_rst_busy", 64'(bus.busy), 64'd0);
    check("midshift_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    rnd_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sel = 4'($urandom_range(15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: b = a;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(sel, a, b, model(sel, a, b));
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end

    rnd_bp = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
